// File: rtl/piso_tx_if.sv
// Handshake and serial-stream bundle for piso_tx: master is the word producer /
// stream consumer, slave is the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, serial_out, serial_valid, frame_start, frame_last, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, serial_out, serial_valid, frame_start, frame_last, busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with frame markers.
// Optional even-parity trailer bit enabled by macro PISO_PARITY_EN.
//
// state | meaning
// IDLE  | no frame in progress, ready for a word
// SHIFT | a frame bit is on serial_out; cnt_q = bits left including this one
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q;
  logic [N-1:0]  sr_q;
  logic [CW-1:0] cnt_q;
  logic          sout_q;
  logic          svalid_q;
  logic          fstart_q;
  logic          flast_q;

  logic [N-1:0]  word_d;
  logic          last_d;
  logic          accept_d;

`ifdef PISO_PARITY_EN
  assign word_d = {bus.load_data, ^bus.load_data};
`else
  assign word_d = bus.load_data;
`endif

  // Ready opens on the final bit so the next word follows without a gap.
  assign last_d         = (state_q == SHIFT) && (cnt_q == CW'(1));
  assign bus.load_ready = !rst && ((state_q == IDLE) || last_d);
  assign accept_d       = bus.load_valid && bus.load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      fstart_q <= 1'b0;
      flast_q  <= 1'b0;
    end else if (accept_d) begin
      state_q  <= SHIFT;
      sout_q   <= word_d[N-1];
      sr_q     <= word_d << 1;
      cnt_q    <= CW'(N);
      svalid_q <= 1'b1;
      fstart_q <= 1'b1;
      flast_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      if (last_d) begin
        state_q  <= IDLE;
        sr_q     <= '0;
        cnt_q    <= '0;
        sout_q   <= 1'b0;
        svalid_q <= 1'b0;
        fstart_q <= 1'b0;
        flast_q  <= 1'b0;
      end else begin
        sout_q   <= sr_q[N-1];
        sr_q     <= sr_q << 1;
        cnt_q    <= cnt_q - CW'(1);
        fstart_q <= 1'b0;
        flast_q  <= (cnt_q == CW'(2));
      end
    end
  end

  assign bus.serial_out   = sout_q;
  assign bus.serial_valid = svalid_q;
  assign bus.frame_start  = fstart_q;
  assign bus.frame_last   = flast_q;
  assign bus.busy         = (state_q == SHIFT);
endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4), parity-aware via PISO_PARITY_EN.
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int N = 5;
  localparam logic [15:0] E1011 = 16'b10111;
  localparam logic [15:0] E0110 = 16'b01100;
  localparam logic [15:0] E0001 = 16'b00011;
  localparam logic [15:0] E1111 = 16'b11110;
  localparam logic [15:0] E0101 = 16'b01010;
`else
  localparam int N = 4;
  localparam logic [15:0] E1011 = 16'b1011;
  localparam logic [15:0] E0110 = 16'b0110;
  localparam logic [15:0] E0001 = 16'b0001;
  localparam logic [15:0] E1111 = 16'b1111;
  localparam logic [15:0] E0101 = 16'b0101;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [15:0] sipo;

  piso_tx_if #(.WIDTH(W)) bus ();

  piso_tx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_svalid"}, 16'(bus.serial_valid), 16'h0);
    check({tag, "_sout"},   16'(bus.serial_out),   16'h0);
    check({tag, "_fstart"}, 16'(bus.frame_start),  16'h0);
    check({tag, "_flast"},  16'(bus.frame_last),   16'h0);
    check({tag, "_busy"},   16'(bus.busy),         16'h0);
  endtask

  // Called one cycle after an accept edge; checks nbits consecutive stream bits.
  task automatic run_bits(input string tag, input logic [15:0] exp, input int nbits,
                          input int raise_k, input logic [W-1:0] raise_data,
                          input int drop_k);
    sipo = '0;
    for (int k = 0; k < nbits; k++) begin
      check($sformatf("%s_sout%0d", tag, k),   16'(bus.serial_out),   16'(exp[nbits-1-k]));
      check($sformatf("%s_svalid%0d", tag, k), 16'(bus.serial_valid), 16'h1);
      check($sformatf("%s_busy%0d", tag, k),   16'(bus.busy),         16'h1);
      check($sformatf("%s_fstart%0d", tag, k), 16'(bus.frame_start),  16'((k % N) == 0));
      check($sformatf("%s_flast%0d", tag, k),  16'(bus.frame_last),   16'((k % N) == N-1));
      check($sformatf("%s_ready%0d", tag, k),  16'(bus.load_ready),   16'((k % N) == N-1));
      sipo = {sipo[14:0], bus.serial_out};
      if (k == raise_k) begin
        bus.load_valid = 1'b1;
        bus.load_data  = raise_data;
      end
      if (k == drop_k) bus.load_valid = 1'b0;
      if (k < nbits-1) tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1111;

    // Reset held 3 cycles with load_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("rst%0d", i));
      check($sformatf("rst%0d_ready", i), 16'(bus.load_ready), 16'h0);
    end
    rst = 1'b0;
    #1;
    check("rst_ready_after", 16'(bus.load_ready), 16'h1);
    tick();
    bus.load_valid = 1'b0;
    run_bits("post_rst", E1111, N, -1, '0, -1);
    tick();
    check_idle("post_rst_end");

    // Single frame 1011
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1011;
    tick();
    bus.load_valid = 1'b0;
    run_bits("single", E1011, N, -1, '0, -1);
    check("single_sipo", sipo & 16'((1 << N) - 1), E1011);
    tick();
    check_idle("single_end");
    check("single_end_ready", 16'(bus.load_ready), 16'h1);

    // Back-to-back 1011 then 0110, valid held
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1011;
    tick();
    run_bits("b2b", (E1011 << N) | E0110, 2*N, 0, 4'b0110, N);
    tick();
    check_idle("b2b_end");

    // Hold-off: 1111 offered during bit 2 of a 0001 frame
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b0001;
    tick();
    bus.load_valid = 1'b0;
    run_bits("hold", (E0001 << N) | E1111, 2*N, 1, 4'b1111, N);
    tick();
    check_idle("hold_end");

    // Reset during bit 2 of 1010
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1010;
    tick();
    bus.load_valid = 1'b0;
    check("mid_bit0", 16'(bus.serial_out), 16'h1);
    tick();
    check("mid_bit1", 16'(bus.serial_out), 16'h0);
    check("mid_bit1_valid", 16'(bus.serial_valid), 16'h1);
    rst = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1111;
    tick();
    check_idle("mid_rst");
    check("mid_rst_ready", 16'(bus.load_ready), 16'h0);
    rst = 1'b0;
    bus.load_data = 4'b0101;
    tick();
    bus.load_valid = 1'b0;
    run_bits("after_rst", E0101, N, -1, '0, -1);
    tick();
    check_idle("after_rst_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that pairs with the team's serial-in, parallel-out shift register. A parallel word is accepted over a valid/ready handshake and shifted out MSB-first, one bit per clock. The stream carries a bit-valid qualifier and frame markers. A SIPO receiver that shifts left on every `serial_valid` cycle reconstructs the original word after `WIDTH` bits.

## Interface
- `WIDTH`, default 4, data word width in bits (≥2)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high; clock clk
- `load_valid`  in  1  producer has a word on `load_data`
- `load_ready`  out  1  transmitter can accept a word this cycle
- `load_data`  in  WIDTH  parallel word, sampled only on accept
- `serial_out`  out  1  serial data bit, MSB first
- `serial_valid`  out  1  `serial_out` carries a frame bit this cycle
- `frame_start`  out  1  high with the first bit of a frame
- `frame_last`  out  1  high with the final bit of a frame
- `busy`  out  1  a frame is in progress

## Operation
- Accept means `load_valid && load_ready` at a rising edge. On accept, `load_data` is captured into an internal shift register and a bit counter is loaded.
- Two states:
  - IDLE: no frame in progress. `load_ready` is 1.
  - SHIFT: bits are being emitted.
- IDLE → SHIFT on accept.
- Each SHIFT cycle drives one bit: the register MSB on `serial_out`, with `serial_valid`=1. The register then shifts left with 0 fill, and the counter decrements.
- Frame length `N` = `WIDTH` (plus 1 with parity, see Configuration).
- On the final bit of a frame, `frame_last`=1 and `load_ready`=1.
  - If an accept occurs on that cycle: stay in SHIFT and load the new word. Its MSB follows the previous last bit with no gap.
  - Otherwise: go to IDLE.
- On bits other than the last, `load_ready`=0. `load_valid` is ignored and `load_data` is not sampled.
- `busy` = (state == SHIFT).
- In IDLE: `serial_out`=0, `serial_valid`=0, `frame_start`=0, `frame_last`=0.
- `load_ready` is derived combinationally from state and counter. It must not depend combinationally on `load_valid`.
- Counter width is `$clog2(N+1)`. The counter never wraps: it is reloaded on accept and stops at the last bit.

## Timing
- Reset (rst high at an edge) puts the block in IDLE and clears the shift register and counter.
  - After that edge: `serial_out`=0, `serial_valid`=0, `frame_start`=0, `frame_last`=0, `busy`=0.
  - `load_ready`=0 while rst is high, and 1 on the first cycle rst is low.
- Latency: accept at edge E0 → bit k (k=0 is MSB) is valid in the cycle after edge E0+k, for k = 0..N-1.
  - `frame_start` is high with bit 0.
  - `frame_last` is high with bit N-1.
- All outputs except `load_ready` are registered.
- Throughput: one word per N cycles when back-to-back.
- Reset mid-frame aborts the frame at once. No further `serial_valid`; the partial frame is discarded. A simultaneous `load_valid` is not accepted.
- `load_valid` held high in IDLE is accepted on the first edge after rst deasserts.

## Configuration
- Macro: `PISO_PARITY_EN`.
- Defined:
  - One even-parity bit (XOR of all `WIDTH` captured data bits) is appended after the LSB, so N = `WIDTH`+1.
  - `frame_last` and the early `load_ready` move to the parity bit.
  - The parity value is computed at accept time.
- Undefined:
  - N = `WIDTH`, and no parity logic is present.

## Test plan
- Reset: hold rst 3 cycles with `load_valid`=1. Required: no accept, all outputs 0. `load_ready`=1 on the first cycle after rst falls.
- Single frame, `WIDTH`=4, `load_data`=4'b1011.
  - Required: `serial_out` = 1,0,1,1 on cycles 1–4 after accept, with `serial_valid`=1 on all four.
  - `frame_start` on cycle 1, `frame_last` on cycle 4, `busy` 1 for exactly 4 cycles.
  - A SIPO model fed these bits reads 4'b1011.
- Back-to-back: 4'b1011 then 4'b0110, `load_valid` held. Required: 8 consecutive valid bits 1,0,1,1,0,1,1,0 with `frame_start` on bits 1 and 5, and `busy` never dropping.
- Hold-off: raise `load_valid` with 4'b1111 during bit 2 of a 4'b0001 frame. Required: no accept until the last-bit cycle; the second frame starts immediately after.
- Reset mid-frame: assert rst during bit 2 of 4'b1010. Required: `serial_valid`=0 from the next cycle, no `frame_last`, and a clean 4'b0101 frame afterward.
- Parity (`PISO_PARITY_EN`, `WIDTH`=4):
  - 4'b1011 → bits 1,0,1,1,1, with `frame_last` on bit 5.
  - 4'b0110 → final bit 0.
